trojan_leak_param: RTL and testbench
====================================

# trojan_leak_param

Parametrised successor to the fixed 32/64 key-leak trojan benchmark. It watches a DATA_W-bit internal bus for a trigger pattern and then captures NCHUNK chunk-wide slices of that bus into a KEY_W-bit shadow register. It then streams the shadow register out LEAK_BITS at a time. It sits beside the PQC datapath as an inserted trojan for detection and reverse-engineering experiments, with width, trigger size, chunking and leak rate all set by parameters.

## Interface
- DATA_W, 64, width of the monitored bus
- TRIG_W, 32, number of low bus bits compared against TRIG_VAL
- TRIG_VAL, 32'h0044ab93, trigger pattern, TRIG_W bits
- CHUNK_W, 16, width of one captured slice
- NCHUNK, 4, number of slices captured per session; KEY_W = CHUNK_W*NCHUNK
- LEAK_BITS, 2, bits emitted per leak beat; KEY_W % LEAK_BITS must be 0
- clk  in  1  sole clock, rising edge
- rst_all_n  in  1  asynchronous active-low reset
- data  in  DATA_W  monitored bus
- leak_valid  out  1  high on each leak beat
- leak_bits  out  LEAK_BITS  current leak beat, LSBs of the shadow register first
- busy  out  1  high in CAPTURE and LEAK
- out  out  1  serial payload from trojan_payload

Derived values: SEL_W = clog2(DATA_W/CHUNK_W); NBEAT = KEY_W/LEAK_BITS. Elaboration fails if TRIG_W+SEL_W > DATA_W or DATA_W % CHUNK_W != 0.

## Operation
- States are IDLE, CAPTURE, LEAK and DEAD. All outputs are registered.
- **Reset** (rst_all_n low, asynchronous):
  - state is IDLE; ctr, sel and K are 0
  - leak_valid, leak_bits, busy and out are 0
- **IDLE**: when data[TRIG_W-1:0]==TRIG_VAL, the block goes to CAPTURE, latches sel <= data[TRIG_W +: SEL_W] and clears ctr.
- **CAPTURE**: each cycle it stores K[ctr*CHUNK_W +: CHUNK_W] <= data[sel*CHUNK_W +: CHUNK_W] and increments ctr. After capture edge NCHUNK-1 it goes to LEAK and clears ctr. All other K bits hold.
- **LEAK**: each cycle it drives leak_valid=1 and leak_bits=K[LEAK_BITS-1:0], then shifts K right by LEAK_BITS with zero fill and increments ctr. After beat NBEAT-1 it leaves LEAK; the next state depends on TROJAN_REARM_EN.
- **DEAD**: the block is inert and all outputs are 0. Only reset leaves DEAD.
- A trigger match seen in CAPTURE, LEAK or DEAD is ignored; sel does not change.
- The ctr width is clog2(max(NCHUNK, NBEAT))+1. ctr never wraps within a session.

## Timing
- Edge T samples the trigger; busy is high from cycle T+1.
- Capture edges are T+1 … T+NCHUNK.
- leak_valid is high for exactly NBEAT consecutive cycles, from T+NCHUNK+1 to T+NCHUNK+NBEAT.
- busy falls at the same edge as leak_valid.
- out follows leak_bits with a 1-cycle latency inside trojan_payload.
- If reset is asserted mid-session, outputs clear immediately. No partial leak resumes after reset.

## Configuration
- TROJAN_REARM_EN defined: after the last beat the block returns to IDLE and can be retriggered any number of times. K is not cleared; it is overwritten by the next capture.
- TROJAN_REARM_EN undefined: after the last beat the block enters DEAD, giving one-shot behaviour until reset.

## Structure
- Shared package trojan_pkg holds:
  - the state enum (IDLE, CAPTURE, LEAK, DEAD)
  - the default TRIG_VAL constant
  - a clog2 helper function
- One sub-module, trojan_payload (parameter LEAK_BITS), converts leak_valid/leak_bits into the serial out.
  - Each beat is emitted over LEAK_BITS cycles, MSB of the beat first.
  - out=0 when the block is idle.
  - The leak beat rate is the NBEAT-cycle rate above. With LEAK_BITS>1, serial output overlaps the following beats; the sub-module double-buffers one beat.

## Test plan
- **Defaults, basic leak**: data=64'h0000_0002_0044_ab93 for 1 cycle, then 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h9999_aaaa_bbbb_cccc, 64'hdddd_eeee_ffff_0000 → sel=2. K=64'hEEEE_AAAA_6666_2222. 32 beats follow, the first leak_bits=2'b10 at T+5.
- **Trigger during LEAK**: TRIG_VAL presented at beat 10 → ignored; the beat count stays 32 and sel is unchanged.
- **Rearm off**: second trigger after completion → no busy and no leak_valid; state is DEAD.
- **Rearm on**: second trigger with sel=0 → a new 32-beat session leaking the low 16-bit chunks.
- **Async reset at beat 5**: rst_all_n pulsed low mid-cycle → outputs are 0 immediately. After release the block is in IDLE and has no leak_valid until a new trigger.
- **Alternate parameters**: DATA_W=128, TRIG_W=48, CHUNK_W=32, NCHUNK=2, LEAK_BITS=4 → NBEAT=16, first leak_valid at T+3, and the beat data matches a reference model.

Source files
------------

// File: rtl/trojan_pkg.sv
// Shared types and helpers for the parametrised key-leak trojan.
package trojan_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      LEAK    = 2'd2,
      DEAD    = 2'd3
   } state_e;

   localparam logic [31:0] DEF_TRIG_VAL = 32'h0044_ab93;

   // Ceiling log2; clog2(1) == 0.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/trojan_leak_param_if.sv
// Monitored bus plus leak outputs of trojan_leak_param.
interface trojan_leak_param_if #(
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned LEAK_BITS = 2
);
   logic [DATA_W-1:0]    data;
   logic                 leak_valid;
   logic [LEAK_BITS-1:0] leak_bits;
   logic                 busy;
   logic                 out;

   modport master (output data, input leak_valid, leak_bits, busy, out);
   modport slave  (input data, output leak_valid, leak_bits, busy, out);
endinterface

// File: rtl/trojan_payload.sv
// Serialises leak beats MSB first, one bit per cycle, with one pending beat buffered.
module trojan_payload
   import trojan_pkg::*;
#(
   parameter int unsigned LEAK_BITS = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 leak_valid,
   input  logic [LEAK_BITS-1:0] leak_bits,
   output logic                 out
);
   localparam int unsigned CNT_W = clog2(LEAK_BITS) + 1;

   logic [LEAK_BITS-1:0] sh;
   logic [LEAK_BITS-1:0] pend;
   logic                 pend_v;
   logic [CNT_W-1:0]     cnt;

   // A beat arriving while the shifter is busy replaces the pending one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh     <= '0;
         pend   <= '0;
         pend_v <= 1'b0;
         cnt    <= '0;
         out    <= 1'b0;
      end else if (cnt != '0) begin
         out <= sh[LEAK_BITS-1];
         sh  <= sh << 1;
         cnt <= cnt - CNT_W'(1);
         if (leak_valid) begin
            pend   <= leak_bits;
            pend_v <= 1'b1;
         end
      end else if (pend_v) begin
         out    <= pend[LEAK_BITS-1];
         sh     <= pend << 1;
         cnt    <= CNT_W'(LEAK_BITS - 1);
         pend   <= leak_bits;
         pend_v <= leak_valid;
      end else if (leak_valid) begin
         out <= leak_bits[LEAK_BITS-1];
         sh  <= leak_bits << 1;
         cnt <= CNT_W'(LEAK_BITS - 1);
      end else begin
         out <= 1'b0;
      end
   end

endmodule

// File: rtl/trojan_leak_param.sv
// Trigger-armed key-leak trojan: captures NCHUNK bus slices, then leaks them LEAK_BITS per beat.
// Define TROJAN_REARM_EN to return to IDLE after a leak instead of going DEAD.
module trojan_leak_param
   import trojan_pkg::*;
#(
   parameter int unsigned       DATA_W    = 64,
   parameter int unsigned       TRIG_W    = 32,
   parameter logic [TRIG_W-1:0] TRIG_VAL  = TRIG_W'(DEF_TRIG_VAL),
   parameter int unsigned       CHUNK_W   = 16,
   parameter int unsigned       NCHUNK    = 4,
   parameter int unsigned       LEAK_BITS = 2
) (
   input  logic               clk,
   input  logic               rst_all_n,
   trojan_leak_param_if.slave bus
);
   localparam int unsigned KEY_W   = CHUNK_W * NCHUNK;
   localparam int unsigned NBEAT   = KEY_W / LEAK_BITS;
   localparam int unsigned SEL_W   = clog2(DATA_W / CHUNK_W);
   localparam int unsigned SEL_R   = (SEL_W == 0) ? 1 : SEL_W;
   localparam int unsigned CTR_MAX = (NCHUNK > NBEAT) ? NCHUNK : NBEAT;
   localparam int unsigned CTR_W   = clog2(CTR_MAX) + 1;

`ifdef TROJAN_REARM_EN
   localparam state_e END_ST = IDLE;
`else
   localparam state_e END_ST = DEAD;
`endif

   if (TRIG_W + SEL_W > DATA_W) begin : g_bad_trig
      $error("trojan_leak_param: TRIG_W + SEL_W exceeds DATA_W");
   end
   if (DATA_W % CHUNK_W != 0) begin : g_bad_chunk
      $error("trojan_leak_param: DATA_W not a multiple of CHUNK_W");
   end
   if (KEY_W % LEAK_BITS != 0) begin : g_bad_leak
      $error("trojan_leak_param: KEY_W not a multiple of LEAK_BITS");
   end

   state_e               state;
   logic [CTR_W-1:0]     ctr;
   logic [SEL_R-1:0]     sel;
   logic [KEY_W-1:0]     k;
   logic                 leak_valid_q;
   logic [LEAK_BITS-1:0] leak_bits_q;
   logic                 busy_q;
   logic                 out_w;

   logic                 trig_c;
   logic [SEL_R-1:0]     sel_in_c;
   logic [CHUNK_W-1:0]   slice_c;

   if (SEL_W == 0) begin : g_nosel
      assign sel_in_c = '0;
   end else begin : g_sel
      assign sel_in_c = bus.data[TRIG_W +: SEL_R];
   end

   assign trig_c  = (bus.data[TRIG_W-1:0] == TRIG_VAL);
   assign slice_c = CHUNK_W'(bus.data >> (32'(sel) * CHUNK_W));

   // Session FSM; leak outputs default low every cycle outside LEAK.
   always_ff @(posedge clk or negedge rst_all_n) begin
      if (!rst_all_n) begin
         state        <= IDLE;
         ctr          <= '0;
         sel          <= '0;
         k            <= '0;
         leak_valid_q <= 1'b0;
         leak_bits_q  <= '0;
         busy_q       <= 1'b0;
      end else begin
         leak_valid_q <= 1'b0;
         leak_bits_q  <= '0;
         case (state)
            IDLE: begin
               busy_q <= 1'b0;
               if (trig_c) begin
                  state  <= CAPTURE;
                  sel    <= sel_in_c;
                  ctr    <= '0;
                  busy_q <= 1'b1;
               end
            end
            CAPTURE: begin
               busy_q <= 1'b1;
               for (int unsigned i = 0; i < NCHUNK; i++) begin
                  if (ctr == CTR_W'(i)) k[i*CHUNK_W +: CHUNK_W] <= slice_c;
               end
               if (ctr == CTR_W'(NCHUNK - 1)) begin
                  state <= LEAK;
                  ctr   <= '0;
               end else begin
                  ctr <= ctr + CTR_W'(1);
               end
            end
            LEAK: begin
               busy_q       <= 1'b1;
               leak_valid_q <= 1'b1;
               leak_bits_q  <= k[LEAK_BITS-1:0];
               k            <= k >> LEAK_BITS;
               if (ctr == CTR_W'(NBEAT - 1)) begin
                  state <= END_ST;
               end else begin
                  ctr <= ctr + CTR_W'(1);
               end
            end
            DEAD: begin
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   trojan_payload #(.LEAK_BITS(LEAK_BITS)) u_payload (
      .clk        (clk),
      .rst_n      (rst_all_n),
      .leak_valid (leak_valid_q),
      .leak_bits  (leak_bits_q),
      .out        (out_w)
   );

   assign bus.leak_valid = leak_valid_q;
   assign bus.leak_bits  = leak_bits_q;
   assign bus.busy       = busy_q;
   assign bus.out        = out_w;

endmodule

// File: tb/tb_trojan_leak_param.sv
// Scoreboard bench for trojan_leak_param: default and alternate parameter instances.
module tb_trojan_leak_param;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [3:0] q0[$];
   logic [3:0] q1[$];

`ifdef TROJAN_REARM_EN
   localparam bit REARM = 1'b1;
`else
   localparam bit REARM = 1'b0;
`endif
   localparam logic [127:0] TRIG0 = 128'h0044_ab93;
   localparam logic [127:0] TRIG1 = 128'hc0de_0044_ab93;

   trojan_leak_param_if #(.DATA_W(64),  .LEAK_BITS(2)) b0();
   trojan_leak_param_if #(.DATA_W(128), .LEAK_BITS(4)) b1();

   trojan_leak_param u0 (.clk(clk), .rst_all_n(rst_n), .bus(b0));
   trojan_leak_param #(.DATA_W(128), .TRIG_W(48), .TRIG_VAL(48'hc0de_0044_ab93),
                       .CHUNK_W(32), .NCHUNK(2), .LEAK_BITS(4))
      u1 (.clk(clk), .rst_all_n(rst_n), .bus(b1));

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [127:0] msk(input int n);
      return (128'd1 << n) - 128'd1;
   endfunction

   function automatic logic [127:0] rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [127:0] filler(input logic [127:0] trig, input int tw);
      logic [127:0] r;
      r = rnd();
      if ((r & msk(tw)) == trig) r = r ^ 128'd1;
      return r;
   endfunction

   function automatic logic get_busy(input int w); return (w == 1) ? b1.busy : b0.busy; endfunction
   function automatic logic get_lv(input int w);   return (w == 1) ? b1.leak_valid : b0.leak_valid; endfunction
   function automatic logic get_out(input int w);  return (w == 1) ? b1.out : b0.out; endfunction
   function automatic logic [3:0] get_lb(input int w);
      return (w == 1) ? b1.leak_bits : {2'b00, b0.leak_bits};
   endfunction

   task automatic set_data(input int w, input logic [127:0] d);
      if (w == 1) b1.data = d;
      else b0.data = d[63:0];
   endtask

   // Monitors: every leak beat must match the next expected beat.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && b0.leak_valid === 1'b1) begin
         if (q0.size() == 0) chk("leak0_extra_beat", 128'(b0.leak_valid), 128'd0);
         else chk("leak0_beat", 128'(b0.leak_bits), 128'(q0.pop_front()));
      end
      if (rst_n === 1'b1 && b1.leak_valid === 1'b1) begin
         if (q1.size() == 0) chk("leak1_extra_beat", 128'(b1.leak_valid), 128'd0);
         else chk("leak1_beat", 128'(b1.leak_bits), 128'(q1.pop_front()));
      end
   end

   // One trigger session; trig_beat/rst_beat < 0 disable those events.
   task automatic sess(input int w, input bit fixed, input logic [1:0] s,
                       input int trig_beat, input bit run, input int rst_beat);
      int nc, cw, tw, lb, nbeat, nmax;
      logic [127:0] trig, word, k, beat0;
      logic [127:0] cap [4];
      logic [127:0] tbl [4];
      tbl = '{128'h1111_2222_3333_4444, 128'h5555_6666_7777_8888,
              128'h9999_aaaa_bbbb_cccc, 128'hdddd_eeee_ffff_0000};
      nc = (w == 1) ? 2 : 4;
      cw = (w == 1) ? 32 : 16;
      tw = (w == 1) ? 48 : 32;
      lb = (w == 1) ? 4 : 2;
      nbeat = nc * cw / lb;
      nmax = nc + nbeat + 6;
      trig = (w == 1) ? TRIG1 : TRIG0;
      word = fixed ? 128'd0 : rnd();
      word = (word & ~msk(tw + 2)) | (128'(s) << tw) | trig;
      for (int i = 0; i < 4; i++) cap[i] = fixed ? tbl[i] : rnd();
      if (w == 0) for (int i = 0; i < 4; i++) cap[i] = cap[i] & msk(64);
      // Reference: shadow key is the selected slices in capture order; beats are its LSB-first groups.
      k = '0;
      for (int i = 0; i < nc; i++) k = k | (((cap[i] >> (int'(s) * cw)) & msk(cw)) << (i * cw));
      beat0 = k & msk(lb);
      if (run) begin
         for (int b = 0; b < nbeat; b++) begin
            if (w == 1) q1.push_back(4'((k >> (b * lb)) & msk(lb)));
            else q0.push_back(4'((k >> (b * lb)) & msk(lb)));
         end
      end
      @(posedge clk); #1; set_data(w, word);
      @(posedge clk); #1;
      for (int n = 0; n <= nmax; n++) begin
         if (n < nc) set_data(w, cap[n]);
         else if (trig_beat >= 0 && n == nc + 1 + trig_beat) set_data(w, (rnd() & ~msk(tw)) | trig);
         else set_data(w, filler(trig, tw));
         @(negedge clk);
         chk("busy", 128'(get_busy(w)), 128'(run && (n <= nc + nbeat)));
         chk("leak_valid", 128'(get_lv(w)), 128'(run && (n >= nc + 1) && (n <= nc + nbeat)));
         if (run && n >= nc + 2 && n <= nc + 1 + lb)
            chk("out_beat0", 128'(get_out(w)), 128'(beat0[lb - 1 - (n - nc - 2)]));
         if (n == nmax) chk("out_idle", 128'(get_out(w)), 128'd0);
         if (rst_beat >= 0 && n == nc + 1 + rst_beat) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_leak_valid", 128'(get_lv(w)), 128'd0);
            chk("rst_leak_bits", 128'(get_lb(w)), 128'd0);
            chk("rst_busy", 128'(get_busy(w)), 128'd0);
            chk("rst_out", 128'(get_out(w)), 128'd0);
            q0.delete();
            q1.delete();
            @(posedge clk); #1 rst_n = 1'b1;
            set_data(w, filler(trig, tw));
            repeat (6) begin
               @(negedge clk);
               chk("post_rst_busy", 128'(get_busy(w)), 128'd0);
               chk("post_rst_leak_valid", 128'(get_lv(w)), 128'd0);
            end
            return;
         end
         @(posedge clk); #1;
      end
      chk("beats_left", 128'((w == 1) ? q1.size() : q0.size()), 128'd0);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1 rst_n = 1'b0;
      @(negedge clk);
      chk("pulse_busy0", 128'(b0.busy), 128'd0);
      chk("pulse_busy1", 128'(b1.busy), 128'd0);
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      b0.data = '0;
      b1.data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_lv0", 128'(b0.leak_valid), 128'd0);
      chk("reset_lb0", 128'(b0.leak_bits), 128'd0);
      chk("reset_busy0", 128'(b0.busy), 128'd0);
      chk("reset_out0", 128'(b0.out), 128'd0);
      chk("reset_lv1", 128'(b1.leak_valid), 128'd0);
      chk("reset_lb1", 128'(b1.leak_bits), 128'd0);
      chk("reset_busy1", 128'(b1.busy), 128'd0);
      chk("reset_out1", 128'(b1.out), 128'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      sess(0, 1'b1, 2'd2, 10, 1'b1, -1);
      sess(0, 1'b0, 2'd0, -1, REARM, -1);
      pulse_reset();
      sess(0, 1'b0, 2'($urandom_range(3)), int'($urandom_range(31)), 1'b1, -1);
      pulse_reset();
      sess(0, 1'b0, 2'($urandom_range(3)), -1, 1'b1, 5);
      sess(0, 1'b0, 2'($urandom_range(3)), -1, 1'b1, -1);
      sess(1, 1'b0, 2'($urandom_range(3)), -1, 1'b1, -1);
      sess(1, 1'b0, 2'($urandom_range(3)), 4, REARM, -1);
      pulse_reset();
      sess(1, 1'b0, 2'($urandom_range(3)), -1, 1'b1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
